hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that produces the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC register. It detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle MUL/DIV occupancy of EX. A two-state FSM with a down-counter sequences multi-cycle stalls, and saturating counters record stall and flush cycles for performance analysis.

## Interface
- MD_LATENCY, 8, total EX-stage occupancy in cycles of a MUL/DIV op; legal range 2..255
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_branch_taken  in  1  the EX instruction is a taken branch or jump
- ex_md_start  in  1  the EX instruction is a MUL/DIV (level signal, held while the op sits in EX)
- cnt_clr  in  1  synchronous clear of both performance counters
- pc_stall  out  1  hold the PC
- if_id_stall  out  1  hold IF/ID (drives the IF/ID `stall` input)
- if_id_flush  out  1  clear IF/ID (drives the IF/ID `flush` input)
- id_ex_stall  out  1  hold ID/EX and the EX stage
- id_ex_flush  out  1  insert a bubble into ID/EX
- md_done  out  1  one-cycle pulse in the final EX cycle of a MUL/DIV op
- stall_count  out  CNT_W  cycles in which pc_stall was 1 (saturating)
- flush_count  out  CNT_W  cycles in which if_id_flush was 1 (saturating)

## Operation
- The FSM has two states, RUN and MD_WAIT. `cnt` is an 8-bit down-counter.
- Load-use hazard (`lu`) = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- RUN, evaluated in priority order:
  1. ex_branch_taken: if_id_flush = 1 and id_ex_flush = 1. The PC is not stalled; it loads the branch target. `lu` and ex_md_start are ignored.
  2. ex_md_start: pc_stall, if_id_stall and id_ex_stall = 1. Load cnt with MD_LATENCY-2 and go to MD_WAIT.
  3. lu: pc_stall = 1, if_id_stall = 1 and id_ex_flush = 1. This inserts one bubble. State stays RUN.
  4. Otherwise all controls are 0.
- MD_WAIT:
  - cnt != 0: pc_stall, if_id_stall and id_ex_stall = 1; decrement cnt. ex_branch_taken and ex_md_start are ignored.
  - cnt == 0: all stall outputs are 0 and md_done = 1; go to RUN. The MUL/DIV op leaves EX at the closing edge of this cycle. ex_md_start, which is still high, is ignored this cycle, so the op is never restarted.
- The stall, flush and md_done outputs are combinational from the state, cnt and the inputs.
- Counters:
  - Each increments by 1 on an edge where its qualifying output is 1, and holds at 2^CNT_W-1 once saturated.
  - cnt_clr clears both counters to 0 and takes priority over an increment in the same cycle.

## Timing
- While rst_n is 0:
  - state = RUN, cnt = 0, stall_count = 0, flush_count = 0.
  - pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush and md_done are all forced to 0, independent of clk.
- A reset asserted mid-MD_WAIT aborts the sequence immediately. After release the FSM is in RUN.
- Load-use: exactly 1 stall cycle per occurrence. The dependent instruction re-evaluates the next cycle against the bubble, so `lu` = 0 on that cycle.
- Branch: flush outputs are asserted for exactly the cycle(s) in which ex_branch_taken = 1. There is zero added latency.
- MUL/DIV started in cycle T:
  - Stall outputs are high for cycles T through T+MD_LATENCY-2, i.e. MD_LATENCY-1 cycles.
  - md_done is high in cycle T+MD_LATENCY-1.
  - The FSM is back in RUN at T+MD_LATENCY.
- Simultaneous events:
  - Branch and MUL/DIV together: the branch wins and no MUL/DIV sequence starts.
  - Branch and load-use together: only the flushes assert.
  - ex_rd == 0 never produces a load-use hazard.

## Test plan
- Reset: assert rst_n = 0 with ex_md_start = 1 and ex_branch_taken = 1 -> all stall/flush outputs and md_done are 0, and both counters read 0. Release reset -> the first clock takes the branch path.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 for one cycle -> pc_stall = 1, if_id_stall = 1 and id_ex_flush = 1 for one cycle, and stall_count reads 1. Repeat with ex_rd = 0 -> no stall.
- Branch priority: ex_branch_taken = 1 while the load-use condition holds -> if_id_flush = 1, id_ex_flush = 1, pc_stall = 0 and flush_count increments.
- MUL/DIV with MD_LATENCY = 8: ex_md_start held high from cycle T until the op leaves EX -> stalls are high for cycles T..T+6, md_done is high at T+7 with stalls low, the state is RUN at T+8 with no restart, and stall_count reads 7.
- MD_LATENCY = 2 boundary: stall lasts exactly 1 cycle and md_done asserts in the next cycle. Assert rst_n = 0 mid-sequence at MD_LATENCY = 8 -> the outputs drop immediately and the next clock after release behaves as RUN.
- Counter rules at CNT_W = 4: force 20 stall cycles -> stall_count saturates at 15. Assert cnt_clr together with a stall -> the count reads 0 after the edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and MUL/DIV
// occupancy stalls, plus saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0]       MD_LOAD = 8'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic pc_stall_raw, if_id_stall_raw, if_id_flush_raw;
  logic id_ex_stall_raw, id_ex_flush_raw, md_done_raw;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_stall_raw    = 1'b0;
    if_id_stall_raw = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_stall_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    md_done_raw     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (ex_md_start) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_stall_raw = 1'b1;
          cnt_d           = MD_LOAD;
          state_d         = MD_WAIT;
        end else if (lu) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end
      end
      MD_WAIT: begin
        if (cnt_q != 8'd0) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_stall_raw = 1'b1;
          cnt_d           = cnt_q - 8'd1;
        end else begin
          // ex_md_start is still high here; returning to RUN without looking at it avoids a restart
          md_done_raw = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Controls are forced low while reset is held, independent of the clock
  assign pc_stall    = rst_n & pc_stall_raw;
  assign if_id_stall = rst_n & if_id_stall_raw;
  assign if_id_flush = rst_n & if_id_flush_raw;
  assign id_ex_stall = rst_n & id_ex_stall_raw;
  assign id_ex_flush = rst_n & id_ex_flush_raw;
  assign md_done     = rst_n & md_done_raw;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (pc_stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (if_id_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: three instances cover the default
// configuration, the MD_LATENCY=2 boundary and 4-bit counter saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_read, ex_branch_taken, ex_md_start, ex_md_start_b, cnt_clr;

  logic        pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_stall_a, id_ex_flush_a, md_done_a;
  logic        pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_stall_b, id_ex_flush_b, md_done_b;
  logic        pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c, md_done_c;
  logic [15:0] stall_count_a, flush_count_a, stall_count_b, flush_count_b;
  logic [3:0]  stall_count_c, flush_count_c;

  logic [5:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_stall_a, id_ex_flush_a, md_done_a};
  assign ctl_b = {pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_stall_b, id_ex_flush_b, md_done_b};
  assign ctl_c = {pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c, md_done_c};

  hazard_ctrl #(.MD_LATENCY(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
    .id_ex_stall(id_ex_stall_a), .id_ex_flush(id_ex_flush_a), .md_done(md_done_a),
    .stall_count(stall_count_a), .flush_count(flush_count_a));

  hazard_ctrl #(.MD_LATENCY(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start_b), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
    .id_ex_stall(id_ex_stall_b), .id_ex_flush(id_ex_flush_b), .md_done(md_done_b),
    .stall_count(stall_count_b), .flush_count(flush_count_b));

  hazard_ctrl #(.MD_LATENCY(8), .CNT_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall_c), .if_id_stall(if_id_stall_c), .if_id_flush(if_id_flush_c),
    .id_ex_stall(id_ex_stall_c), .id_ex_flush(id_ex_flush_c), .md_done(md_done_c),
    .stall_count(stall_count_c), .flush_count(flush_count_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, md_done}
  localparam logic [5:0] Z = 6'b000000;
  localparam logic [5:0] L = 6'b110010;
  localparam logic [5:0] B = 6'b001010;
  localparam logic [5:0] S = 6'b110100;
  localparam logic [5:0] D = 6'b000001;

  typedef struct {
    string      tag;
    int         sel;
    logic [5:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  m_sa = 0, m_fa = 0, m_sc = 0, m_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive happens before the call; outputs compared mid-cycle, counter model advanced at the edge
  task automatic step(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    sb_t e;
    sbq.push_back('{tag, 0, ea});
    sbq.push_back('{tag, 1, eb});
    sbq.push_back('{tag, 2, ea});
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        0:       chk({e.tag, "_a"}, 32'(ctl_a), 32'(e.exp));
        1:       chk({e.tag, "_b"}, 32'(ctl_b), 32'(e.exp));
        default: chk({e.tag, "_c"}, 32'(ctl_c), 32'(e.exp));
      endcase
    end
    chk({tag, "_stall_cnt_a"}, 32'(stall_count_a), 32'(m_sa));
    chk({tag, "_flush_cnt_a"}, 32'(flush_count_a), 32'(m_fa));
    chk({tag, "_stall_cnt_c"}, 32'(stall_count_c), 32'(m_sc));
    chk({tag, "_flush_cnt_c"}, 32'(flush_count_c), 32'(m_fc));
    @(posedge clk);
    if (cnt_clr) begin
      m_sa = 0; m_fa = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (ea[5]) begin
        if (m_sa < 65535) m_sa++;
        if (m_sc < 15) m_sc++;
      end
      if (ea[3]) begin
        if (m_fa < 65535) m_fa++;
        if (m_fc < 15) m_fc++;
      end
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0;
    ex_md_start = 1'b1; ex_md_start_b = 1'b1; ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b0;

    #2;
    chk("rst_ctl_a", 32'(ctl_a), 32'(Z));
    chk("rst_ctl_b", 32'(ctl_b), 32'(Z));
    chk("rst_ctl_c", 32'(ctl_c), 32'(Z));
    chk("rst_stall_cnt_a", 32'(stall_count_a), 32'd0);
    chk("rst_flush_cnt_a", 32'(flush_count_a), 32'd0);
    chk("rst_stall_cnt_b", 32'(stall_count_b), 32'd0);
    @(posedge clk); #1;
    chk("rst_clk_ctl_a", 32'(ctl_a), 32'(Z));
    rst_n = 1'b1;

    step("rel_branch", B, B);
    ex_branch_taken = 1'b0; ex_md_start = 1'b0; ex_md_start_b = 1'b0;
    step("lu_rs2", L, L);
    ex_mem_read = 1'b0;
    step("bubble", Z, Z);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    step("rd0", Z, Z);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; id_rs2 = 5'd3;
    step("lu_rs1", L, L);
    id_uses_rs1 = 1'b0;
    step("no_use", Z, Z);
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
    step("br_lu", B, B);
    ex_mem_read = 1'b0; ex_md_start = 1'b1; ex_md_start_b = 1'b1;
    step("br_md", B, B);
    ex_branch_taken = 1'b0; ex_md_start = 1'b0; ex_md_start_b = 1'b0;
    step("br_md_idle", Z, Z);

    ex_md_start = 1'b1;
    for (int i = 0; i < 7; i++) step("md8_stall", S, Z);
    step("md8_done", D, Z);
    ex_md_start = 1'b0; ex_branch_taken = 1'b1;
    step("md8_run", B, B);
    ex_branch_taken = 1'b0;
    step("md8_idle", Z, Z);

    ex_md_start_b = 1'b1;
    step("md2_stall", Z, S);
    step("md2_done", Z, D);
    ex_md_start_b = 1'b0;
    step("md2_run", Z, Z);

    ex_md_start = 1'b1;
    for (int i = 0; i < 3; i++) step("abort_stall", S, Z);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl_a", 32'(ctl_a), 32'(Z));
    chk("abort_ctl_c", 32'(ctl_c), 32'(Z));
    chk("abort_stall_cnt_a", 32'(stall_count_a), 32'd0);
    m_sa = 0; m_fa = 0; m_sc = 0; m_fc = 0;
    ex_md_start = 1'b0; ex_branch_taken = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst_branch", B, B);
    ex_branch_taken = 1'b0;
    step("post_rst_idle", Z, Z);

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    for (int i = 0; i < 20; i++) step("sat", L, L);
    cnt_clr = 1'b1;
    step("clr_with_stall", L, L);
    cnt_clr = 1'b0; ex_mem_read = 1'b0;
    step("after_clr", Z, Z);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
